// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the bus responder
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic        RW_WRITE    = 1'b1;
  localparam logic        RW_READ     = 1'b0;
  localparam logic [31:0] RDATA_FAULT = 32'h0;

  // Any address bit above the implemented word range is a fault.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned bits);
    return (addr >> bits) != 32'd0;
  endfunction

endpackage

// File: rtl/word_ram.sv
// rtl/word_ram.sv - single-port word memory, synchronous write, registered read
module word_ram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  // The read register only moves on a read, so it holds across writes.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - request/wait/response memory target with address fault decode
module bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_rw;
  logic        rd_zero;

  logic        enter_resp;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_rw;
  logic        fault;
  logic [31:0] ram_q;

  // With no wait states the access fires on the sampling edge, so the
  // request inputs stand in for the latches that are loading on that edge.
  always_comb begin
    acc_addr   = (state == IDLE) ? address : lat_addr;
    acc_wdata  = (state == IDLE) ? wdata   : lat_wdata;
    acc_rw     = (state == IDLE) ? rw      : lat_rw;
    fault      = addr_fault(acc_addr, ADDR_BITS);
    enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));
  end

  word_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clock (clock),
    .en    (enter_resp && !fault && !reset),
    .we    (acc_rw == RW_WRITE),
    .addr  (acc_addr[ADDR_BITS-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  assign rdata = rd_zero ? RDATA_FAULT : ram_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rd_zero   <= 1'b1;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_rw    <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= address;
            lat_wdata <= wdata;
            lat_rw    <= rw;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        ready <= 1'b1;
        err   <= fault;
        if (fault) begin
          rd_zero <= 1'b1;
        end else if (acc_rw == RW_READ) begin
          rd_zero <= 1'b0;
        end
      end
    end
  end

endmodule
